// File: rtl/dcache_pkg.sv
// Shared constants and types for the data-cache store path.
package dcache_pkg;
  localparam logic SZ_4B   = 1'b0;
  localparam logic SZ_8B   = 1'b1;
  localparam int   BLK_LSB = 3;

  typedef struct packed {
    logic        size;
    logic [31:0] addr;
    logic [63:0] data;
  } st_entry_t;

  localparam int ENTRY_W = $bits(st_entry_t);

  // Block index of the last byte touched; the add wraps mod 2^32 on purpose.
  function automatic logic [31-BLK_LSB:0] blk_last(input logic [31:0] addr, input logic size);
    logic [31:0] last_byte;
    last_byte = addr + ((size == SZ_8B) ? 32'd7 : 32'd3);
    return last_byte[31:BLK_LSB];
  endfunction
endpackage

// File: rtl/dstore_buffer_if.sv
// Store-in, cache-write-out and load-check signals of the store buffer.
interface dstore_buffer_if #(parameter int PTR_W = 2);
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_address;
  logic [63:0]      st_data;
  logic             st_size;
  logic             wr_req_valid;
  logic             wr_req_ready;
  logic [31:0]      wr_req_address;
  logic [63:0]      wr_req_data;
  logic             wr_size_out;
  logic [31:0]      ld_chk_address;
  logic             ld_chk_size;
  logic             ld_conflict;
  logic [PTR_W:0]   count;
  logic             empty;

  modport slave (
    input  st_valid, st_address, st_data, st_size, wr_req_ready, ld_chk_address, ld_chk_size,
    output st_ready, wr_req_valid, wr_req_address, wr_req_data, wr_size_out, ld_conflict,
           count, empty
  );

  modport master (
    output st_valid, st_address, st_data, st_size, wr_req_ready, ld_chk_address, ld_chk_size,
    input  st_ready, wr_req_valid, wr_req_address, wr_req_data, wr_size_out, ld_conflict,
           count, empty
  );
endinterface

// File: rtl/dsb_overlap.sv
// Conservative 8-byte-block overlap test between two (address, size) accesses.
module dsb_overlap import dcache_pkg::*; (
  input  logic [31:0] i_a_addr,
  input  logic        i_a_size,
  input  logic [31:0] i_b_addr,
  input  logic        i_b_size,
  output logic        o_overlap
);
  logic [31-BLK_LSB:0] w_a_first, w_a_last, w_b_first, w_b_last;

  assign w_a_first = i_a_addr[31:BLK_LSB];
  assign w_a_last  = blk_last(i_a_addr, i_a_size);
  assign w_b_first = i_b_addr[31:BLK_LSB];
  assign w_b_last  = blk_last(i_b_addr, i_b_size);

  assign o_overlap = (w_a_first == w_b_first) | (w_a_first == w_b_last) |
                     (w_a_last  == w_b_first) | (w_a_last  == w_b_last);
endmodule

// File: rtl/register.sv
// Enabled register cell; HAS_RESET=0 builds a storage flop with no reset.
module register #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               HAS_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  logic             w_unused_reset;

  assign w_unused_reset = reset;
  assign o_q            = r_q;

  generate
    if (HAS_RESET) begin : g_rst
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_q <= RESET_VAL;
        end else if (i_en) begin
          r_q <= i_d;
        end
      end
    end else begin : g_norst
      always_ff @(posedge clk) begin
        if (i_en) begin
          r_q <= i_d;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/dstore_buffer.sv
// In-order store queue feeding the dcache write port, with load-overlap detection.
module dstore_buffer import dcache_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  dstore_buffer_if.slave   bus
);
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_nxt;
  logic             w_full, w_empty, w_push, w_pop;
  st_entry_t        w_st_entry, w_head_entry;
  st_entry_t        w_entry_q [DEPTH];
  logic [DEPTH-1:0] w_occ;
  logic [DEPTH:0]   w_hit;

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.st_valid & ~w_full;
  assign w_pop   = ~w_empty & bus.wr_req_ready;

  assign w_count_nxt = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

  assign w_st_entry.size = bus.st_size;
  assign w_st_entry.addr = bus.st_address;
  assign w_st_entry.data = bus.st_data;

  register #(.WIDTH(PTR_W)) u_head (
    .clk(clk), .reset(reset), .i_en(w_pop), .i_d(r_head + PTR_W'(1)), .o_q(r_head)
  );

  register #(.WIDTH(PTR_W)) u_tail (
    .clk(clk), .reset(reset), .i_en(w_push), .i_d(r_tail + PTR_W'(1)), .o_q(r_tail)
  );

  register #(.WIDTH(PTR_W+1)) u_count (
    .clk(clk), .reset(reset), .i_en(1'b1), .i_d(w_count_nxt), .o_q(r_count)
  );

  // An entry is occupied when its distance from head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] w_rel;

    register #(.WIDTH(ENTRY_W), .HAS_RESET(1'b0)) u_entry (
      .clk(clk), .reset(reset), .i_en(w_push && (r_tail == PTR_W'(i))),
      .i_d(w_st_entry), .o_q(w_entry_q[i])
    );

    assign w_rel    = PTR_W'(i) - r_head;
    assign w_occ[i] = ({1'b0, w_rel} < r_count);

    dsb_overlap u_ovl (
      .i_a_addr(bus.ld_chk_address), .i_a_size(bus.ld_chk_size),
      .i_b_addr(w_entry_q[i].addr),  .i_b_size(w_entry_q[i].size),
      .o_overlap(w_hit[i])
    );
  end

  dsb_overlap u_ovl_in (
    .i_a_addr(bus.ld_chk_address), .i_a_size(bus.ld_chk_size),
    .i_b_addr(bus.st_address),     .i_b_size(bus.st_size),
    .o_overlap(w_hit[DEPTH])
  );

  assign bus.ld_conflict = |(w_hit & {w_push, w_occ});

  // Storage is never cleared, so the head view is forced to zero while empty.
  assign w_head_entry       = w_entry_q[r_head];
  assign bus.wr_req_valid   = ~w_empty;
  assign bus.wr_req_address = w_empty ? '0 : w_head_entry.addr;
  assign bus.wr_req_data    = w_empty ? '0 : w_head_entry.data;
  assign bus.wr_size_out    = w_empty ? SZ_4B : w_head_entry.size;
  assign bus.st_ready       = ~w_full;
  assign bus.empty          = w_empty;
  assign bus.count          = r_count;
endmodule
